// File: rtl/ringosc_meas_ctrl_if.sv
// Measurement-controller signal bundle between the ref_clk controller and its surroundings.
// Min/max tracking signals exist only when RINGOSC_MEAS_MINMAX_EN is defined.
interface ringosc_meas_ctrl_if;
    logic        meas_en;
    logic        osc_latch_req;
    logic        osc_latch_ack;
    logic [31:0] osc_counter_latch;
    logic [31:0] meas_delta;
    logic        meas_valid;
    logic        meas_timeout;
    logic        meas_busy;
`ifdef RINGOSC_MEAS_MINMAX_EN
    logic        minmax_clr;
    logic [31:0] meas_min;
    logic [31:0] meas_max;
`endif

    modport master (
        input  meas_en, osc_latch_ack, osc_counter_latch,
`ifdef RINGOSC_MEAS_MINMAX_EN
        input  minmax_clr,
        output meas_min, meas_max,
`endif
        output osc_latch_req, meas_delta, meas_valid, meas_timeout, meas_busy
    );

    modport slave (
        output meas_en, osc_latch_ack, osc_counter_latch,
`ifdef RINGOSC_MEAS_MINMAX_EN
        output minmax_clr,
        input  meas_min, meas_max,
`endif
        input  osc_latch_req, meas_delta, meas_valid, meas_timeout, meas_busy
    );
endinterface

// File: rtl/ringosc_meas_ctrl.sv
// Ring-oscillator measurement controller: gate window, latch req/ack handshake, per-window delta,
// dead-oscillator timeout. Optional min/max delta tracking under RINGOSC_MEAS_MINMAX_EN.
module ringosc_meas_ctrl #(
    parameter int GATE_CYCLES    = 1000,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                ref_clk,
    input  logic                osc_rst,
    ringosc_meas_ctrl_if.master bus
);
    localparam int DATA_W = 32;
    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_GATE, S_REQ, S_SAMPLE, S_REL, S_ERR
    } state_t;

    state_t            r_state;
    logic [GW-1:0]     r_gate_cnt;
    logic [TW-1:0]     r_wait_cnt;
    logic [DATA_W-1:0] r_s0;
    logic              r_s0_vld;
    logic [DATA_W-1:0] r_prev_cnt;
    logic              r_primed;
    logic              r_abort;
    logic              r_req;
    logic [DATA_W-1:0] r_delta;
    logic              r_valid;
    logic              r_timeout;
    logic              r_busy;

    logic              w_accept;
    logic              w_emit;
    logic [DATA_W-1:0] w_new_delta;

    // Counter wrap is legal, so the modular difference is the edge count.
    function automatic logic [DATA_W-1:0] f_wrap_delta(input logic [DATA_W-1:0] cur,
                                                       input logic [DATA_W-1:0] prev);
        return cur - prev;
    endfunction

    // Two matching consecutive reads guard against a latch still settling across the CDC.
    assign w_accept    = (r_state == S_SAMPLE) && r_s0_vld && (bus.osc_counter_latch == r_s0);
    assign w_emit      = w_accept && r_primed && !r_abort && bus.meas_en;
    assign w_new_delta = f_wrap_delta(bus.osc_counter_latch, r_prev_cnt);

    always_ff @(posedge ref_clk or posedge osc_rst) begin
        if (osc_rst) begin
            r_state    <= S_IDLE;
            r_gate_cnt <= '0;
            r_wait_cnt <= '0;
            r_s0       <= '0;
            r_s0_vld   <= 1'b0;
            r_prev_cnt <= '0;
            r_primed   <= 1'b0;
            r_abort    <= 1'b0;
            r_req      <= 1'b0;
            r_delta    <= '0;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_req    <= 1'b0;
                    r_primed <= 1'b0;
                    r_abort  <= 1'b0;
                    if (!bus.meas_en) begin
                        r_timeout <= 1'b0;
                    end else if (!r_timeout) begin
                        r_state    <= S_GATE;
                        r_gate_cnt <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                S_GATE: begin
                    if (!bus.meas_en) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_gate_cnt == GATE_LAST) begin
                        r_state    <= S_REQ;
                        r_req      <= 1'b1;
                        r_wait_cnt <= '0;
                        r_abort    <= 1'b0;
                    end else begin
                        r_gate_cnt <= r_gate_cnt + GW'(1);
                    end
                end
                S_REQ: begin
                    if (!bus.meas_en) r_abort <= 1'b1;
                    if (bus.osc_latch_ack) begin
                        r_state  <= S_SAMPLE;
                        r_s0_vld <= 1'b0;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_state <= S_ERR;
                        r_req   <= 1'b0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TW'(1);
                    end
                end
                S_SAMPLE: begin
                    if (!bus.meas_en) r_abort <= 1'b1;
                    r_s0     <= bus.osc_counter_latch;
                    r_s0_vld <= 1'b1;
                    if (w_accept) begin
                        r_state    <= S_REL;
                        r_req      <= 1'b0;
                        r_wait_cnt <= '0;
                        r_prev_cnt <= bus.osc_counter_latch;
                        r_primed   <= 1'b1;
                        if (w_emit) begin
                            r_delta <= w_new_delta;
                            r_valid <= 1'b1;
                        end
                    end
                end
                S_REL: begin
                    if (!bus.osc_latch_ack) begin
                        if (bus.meas_en) begin
                            r_state    <= S_GATE;
                            r_gate_cnt <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_state <= S_ERR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TW'(1);
                    end
                end
                S_ERR: begin
                    r_req     <= 1'b0;
                    r_timeout <= 1'b1;
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.osc_latch_req = r_req;
    assign bus.meas_delta    = r_delta;
    assign bus.meas_valid    = r_valid;
    assign bus.meas_timeout  = r_timeout;
    assign bus.meas_busy     = r_busy;

`ifdef RINGOSC_MEAS_MINMAX_EN
    function automatic logic [DATA_W-1:0] f_min(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        return (b < a) ? b : a;
    endfunction

    function automatic logic [DATA_W-1:0] f_max(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        return (b > a) ? b : a;
    endfunction

    logic [DATA_W-1:0] r_min;
    logic [DATA_W-1:0] r_max;

    // Cleared values make the first tracked delta load both bounds; updates align with meas_valid.
    always_ff @(posedge ref_clk or posedge osc_rst) begin
        if (osc_rst) begin
            r_min <= '1;
            r_max <= '0;
        end else if (bus.minmax_clr) begin
            r_min <= '1;
            r_max <= '0;
        end else if (w_emit) begin
            r_min <= f_min(r_min, w_new_delta);
            r_max <= f_max(r_max, w_new_delta);
        end
    end

    assign bus.meas_min = r_min;
    assign bus.meas_max = r_max;
`endif
endmodule

// File: tb/tb_ringosc_meas_ctrl.sv
// Scoreboard bench for ringosc_meas_ctrl: counter/ack stimulus model, expected deltas queued by
// the stimulus and checked by an independent monitor on each meas_valid.
`timescale 1ns/1ps
module tb_ringosc_meas_ctrl;
    localparam int GATE = 30;
    localparam int TMO  = 64;

    logic ref_clk = 1'b0;
    logic osc_rst;
    always #5 ref_clk = ~ref_clk;

    ringosc_meas_ctrl_if bus();

    ringosc_meas_ctrl #(.GATE_CYCLES(GATE), .TIMEOUT_CYCLES(TMO)) dut (
        .ref_clk(ref_clk),
        .osc_rst(osc_rst),
        .bus    (bus)
    );

    // Counter block model: ticks every 3 ref_clk while req=0, ack follows req by 2 cycles.
    logic [31:0] cnt;
    logic [1:0]  div;
    logic        a1, a2;
    logic        preload_req;
    logic [31:0] preload_val;
    int          ack_mode;
    logic        lat_sel;
    logic [31:0] lat_fix;

    always @(posedge ref_clk) begin
        if (osc_rst) begin
            a1 <= 1'b0;
            a2 <= 1'b0;
        end else begin
            a1 <= bus.osc_latch_req;
            a2 <= a1;
        end
        if (preload_req) begin
            cnt <= preload_val;
            div <= 2'd0;
        end else if (!bus.osc_latch_req) begin
            if (div == 2'd2) begin
                div <= 2'd0;
                cnt <= cnt + 32'd1;
            end else begin
                div <= div + 2'd1;
            end
        end
    end

    assign bus.osc_latch_ack     = (ack_mode == 1) ? 1'b0 : (ack_mode == 2) ? 1'b1 : a2;
    assign bus.osc_counter_latch = lat_sel ? lat_fix : cnt;

    int          checks;
    int          errors;
    int          n_valid;
    int          nv;
    int          n;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge ref_clk);
    endtask

    task automatic wait_req(input logic val, input int maxc);
        int k;
        k = 0;
        while (bus.osc_latch_req !== val && k < maxc) begin
            @(negedge ref_clk);
            k++;
        end
        check("wait_req", {31'd0, bus.osc_latch_req}, {31'd0, val});
    endtask

    task automatic wait_drain(input int maxc);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < maxc) begin
            @(negedge ref_clk);
            k++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    task automatic wait_idle(input int maxc);
        int k;
        k = 0;
        while (bus.meas_busy !== 1'b0 && k < maxc) begin
            @(negedge ref_clk);
            k++;
        end
        check("idle_busy", {31'd0, bus.meas_busy}, 32'd0);
    endtask

    task automatic start_run(input logic [31:0] pre);
        preload_val = pre;
        preload_req = 1'b1;
        bus.meas_en = 1'b1;
        tick(1);
        preload_req = 1'b0;
    endtask

    task automatic stop_run();
        bus.meas_en = 1'b0;
        wait_idle(200);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; n_valid = 0;
        osc_rst = 1'b1; bus.meas_en = 1'b0;
        ack_mode = 0; lat_sel = 1'b0; lat_fix = 32'd0;
        preload_req = 1'b1; preload_val = 32'd0;
`ifdef RINGOSC_MEAS_MINMAX_EN
        bus.minmax_clr = 1'b0;
`endif
        fork
            forever begin
                @(negedge ref_clk);
                if (osc_rst === 1'b0 && bus.meas_valid === 1'b1) begin
                    n_valid++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid: got delta %0h required no valid", bus.meas_delta);
                    end else begin
                        check("delta", bus.meas_delta, exp_q.pop_front());
                    end
                end
            end
        join_none

        tick(3);
        check("rst_req",     {31'd0, bus.osc_latch_req}, 32'd0);
        check("rst_delta",   bus.meas_delta, 32'd0);
        check("rst_valid",   {31'd0, bus.meas_valid}, 32'd0);
        check("rst_timeout", {31'd0, bus.meas_timeout}, 32'd0);
        check("rst_busy",    {31'd0, bus.meas_busy}, 32'd0);
`ifdef RINGOSC_MEAS_MINMAX_EN
        check("rst_min", bus.meas_min, 32'hFFFF_FFFF);
        check("rst_max", bus.meas_max, 32'h0);
`endif
        osc_rst = 1'b0;
        tick(2);

        // T1: each steady window spans REL(3)+GATE(30)=33 req-low cycles -> 11 ticks
        exp_q.push_back(32'd11); exp_q.push_back(32'd11); exp_q.push_back(32'd11);
        start_run(32'd0);
        tick(1);
        check("t1_busy", {31'd0, bus.meas_busy}, 32'd1);
        wait_drain(400);
        check("t1_valid_count", n_valid, 3);
        stop_run();

        // T2: counter crosses 2^32 between windows
        exp_q.push_back(32'd11); exp_q.push_back(32'd11);
        start_run(32'hFFFF_FFF0);
        wait_drain(300);
        check("t2_delta_hold", bus.meas_delta, 32'd11);
        stop_run();

        // T3: ack never rises -> IDLE+GATE(30)+REQ(64)+ERR(1) = 96 edges after enable
        ack_mode = 1;
        bus.meas_en = 1'b1;
        n = 0;
        while (bus.meas_timeout !== 1'b1 && n < 500) begin
            @(negedge ref_clk);
            n++;
        end
        check("t3_latency", n, 96);
        check("t3_req", {31'd0, bus.osc_latch_req}, 32'd0);
        check("t3_busy", {31'd0, bus.meas_busy}, 32'd0);
        tick(10);
        check("t3_sticky", {31'd0, bus.meas_timeout}, 32'd1);
        check("t3_stay_idle", {31'd0, bus.meas_busy}, 32'd0);
        bus.meas_en = 1'b0;
        tick(2);
        check("t3_cleared", {31'd0, bus.meas_timeout}, 32'd0);
        ack_mode = 0;
        exp_q.push_back(32'd11);
        start_run(32'd0);
        wait_drain(300);
        stop_run();

        // T4: ack stuck high after release -> REQ(1)+SAMPLE(2)+REL(64)+ERR(1) = 68 edges
        start_run(32'd0);
        wait_req(1'b1, 100);
        ack_mode = 2;
        n = 0;
        while (bus.meas_timeout !== 1'b1 && n < 500) begin
            @(negedge ref_clk);
            n++;
        end
        check("t4_latency", n, 68);
        check("t4_req", {31'd0, bus.osc_latch_req}, 32'd0);
        check("t4_busy", {31'd0, bus.meas_busy}, 32'd0);
        bus.meas_en = 1'b0;
        ack_mode = 0;
        tick(2);
        check("t4_cleared", {31'd0, bus.meas_timeout}, 32'd0);

        // T5: first window latches 10; second window latch settles at 500 -> delta 490
        exp_q.push_back(32'd490);
        start_run(32'd0);
        wait_req(1'b1, 100);
        wait_req(1'b0, 100);
        wait_req(1'b1, 100);
        lat_sel = 1'b1;
        lat_fix = 32'd100;
        tick(4);
        lat_fix = 32'd200;
        tick(1);
        lat_fix = 32'd300;
        tick(1);
        lat_fix = 32'd500;
        wait_drain(50);
        stop_run();
        lat_sel = 1'b0;

        // T6a: meas_en drops during SAMPLE of a valid-producing window
        start_run(32'd0);
        wait_req(1'b1, 100);
        wait_req(1'b0, 100);
        wait_req(1'b1, 100);
        tick(4);
        bus.meas_en = 1'b0;
        nv = n_valid;
        wait_req(1'b0, 20);
        wait_idle(50);
        check("t6_ack_low", {31'd0, bus.osc_latch_ack}, 32'd0);
        check("t6_no_timeout", {31'd0, bus.meas_timeout}, 32'd0);
        tick(5);
        check("t6_no_valid", n_valid, nv);

        // T6b: async reset in GATE clears outputs immediately
        exp_q.push_back(32'd11);
        start_run(32'd0);
        wait_drain(200);
        tick(10);
        check("t6_delta_before", bus.meas_delta, 32'd11);
        check("t6_busy_before", {31'd0, bus.meas_busy}, 32'd1);
        #2 osc_rst = 1'b1;
        #1;
        check("t6r_req",     {31'd0, bus.osc_latch_req}, 32'd0);
        check("t6r_delta",   bus.meas_delta, 32'd0);
        check("t6r_valid",   {31'd0, bus.meas_valid}, 32'd0);
        check("t6r_busy",    {31'd0, bus.meas_busy}, 32'd0);
        check("t6r_timeout", {31'd0, bus.meas_timeout}, 32'd0);
        @(negedge ref_clk);
        bus.meas_en = 1'b0;
        tick(1);
        osc_rst = 1'b0;
        tick(2);

`ifdef RINGOSC_MEAS_MINMAX_EN
        // T7: latched 100,110,117,129 -> deltas 10,7,12
        bus.minmax_clr = 1'b1;
        tick(1);
        bus.minmax_clr = 1'b0;
        check("t7_clr_min0", bus.meas_min, 32'hFFFF_FFFF);
        check("t7_clr_max0", bus.meas_max, 32'h0);
        exp_q.push_back(32'd10); exp_q.push_back(32'd7); exp_q.push_back(32'd12);
        lat_sel = 1'b1;
        lat_fix = 32'd100;
        start_run(32'd0);
        wait_req(1'b1, 100);
        wait_req(1'b0, 100);
        wait_req(1'b1, 100);
        lat_fix = 32'd110;
        wait_req(1'b0, 100);
        wait_req(1'b1, 100);
        lat_fix = 32'd117;
        wait_req(1'b0, 100);
        wait_req(1'b1, 100);
        lat_fix = 32'd129;
        wait_drain(50);
        check("t7_min", bus.meas_min, 32'd7);
        check("t7_max", bus.meas_max, 32'd12);
        stop_run();
        lat_sel = 1'b0;
        bus.minmax_clr = 1'b1;
        tick(1);
        bus.minmax_clr = 1'b0;
        check("t7_clr_min", bus.meas_min, 32'hFFFF_FFFF);
        check("t7_clr_max", bus.meas_max, 32'h0);
`endif

        tick(5);
        check("final_queue", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
